// File: rtl/exhaustive_sweep_checker_pkg.sv
// exhaustive_sweep_checker_pkg: shared state encoding, fail codes and default golden mask
package exhaustive_sweep_checker_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  localparam logic [1:0] FAIL_NONE = 2'b00;
  localparam logic [1:0] FAIL_DISAGREE = 2'b01;
  localparam logic [1:0] FAIL_GOLDEN = 2'b10;
  localparam logic [15:0] GOLDEN_DEFAULT = 16'hC0A0;
endpackage

// File: rtl/exhaustive_sweep_checker_sweep_judge.sv
// exhaustive_sweep_checker_sweep_judge: combinational agreement and golden-mask verdict for one vector
module exhaustive_sweep_checker_sweep_judge
  import exhaustive_sweep_checker_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int N_IMPL = 3,
  parameter logic [(1<<IN_W)-1:0] GOLDEN = GOLDEN_DEFAULT
) (
  input  logic [N_IMPL-1:0] dut_out,
  input  logic [IN_W-1:0]   vec,
  output logic              agree,
  output logic              correct,
  output logic [1:0]        code
);
  always_comb begin
    agree = (&dut_out) | ~(|dut_out);
    correct = agree && (dut_out[0] == GOLDEN[vec]);
    code = !agree ? FAIL_DISAGREE : !correct ? FAIL_GOLDEN : FAIL_NONE;
  end
endmodule

// File: rtl/exhaustive_sweep_checker.sv
// exhaustive_sweep_checker: sweeps every input vector onto vec and judges dut_out per vector, reporting the first failure
module exhaustive_sweep_checker
  import exhaustive_sweep_checker_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int N_IMPL = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<IN_W)-1:0] GOLDEN = GOLDEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   vec,
  input  logic [N_IMPL-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IN_W-1:0]   fail_vec,
  output logic [1:0]        fail_code
);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [IN_W-1:0] LAST = '1;
  state_t state;
  logic [CW-1:0] cnt;
  logic agree, correct;
  logic [1:0] code;
  exhaustive_sweep_checker_sweep_judge #(.IN_W(IN_W), .N_IMPL(N_IMPL), .GOLDEN(GOLDEN)) u_judge (
    .dut_out(dut_out),
    .vec(vec),
    .agree(agree),
    .correct(correct),
    .code(code)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_vec <= '0;
      fail_code <= FAIL_NONE;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          vec <= '0;
          cnt <= '0;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          fail_vec <= '0;
          fail_code <= FAIL_NONE;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 1)) state <= CHECK;
        end
        CHECK: begin
          if (!agree || !correct) begin
            fail_code <= code;
            fail_vec <= vec;
            pass <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else if (vec == LAST) begin
            pass <= 1'b1;
            fail_code <= FAIL_NONE;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            vec <= vec + 1'b1;
            cnt <= '0;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb_exhaustive_sweep_checker: randomized and directed sweeps of two checker instances against a spec-level reference
module tb_exhaustive_sweep_checker;
  localparam logic [15:0] GOLD = 16'hC0A0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [3:0] vec0, vec1, fv0, fv1;
  logic [2:0] out0, out1;
  logic busy0, busy1, done0, done1, pass0, pass1;
  logic [1:0] fc0, fc1;
  int checks = 0, failures = 0;
  int m_mode = 0, m_fv = 0, sel = 0;
  logic [2:0] m_pat = 3'b000;
  always #5 clk = ~clk;
  function automatic logic [2:0] impl(input logic [3:0] v, input int mode, input int fv, input logic [2:0] pat);
    logic [2:0] b;
    b = {3{GOLD[v]}};
    if (int'(v) != fv) return b;
    return mode == 1 ? b ^ 3'b010 : mode == 2 ? 3'b000 : mode == 3 ? b ^ pat : b;
  endfunction
  assign out0 = impl(vec0, m_mode, m_fv, m_pat);
  assign out1 = impl(vec1, m_mode, m_fv, m_pat);
  wire [3:0] vec_s = sel != 0 ? vec1 : vec0;
  wire [3:0] fv_s = sel != 0 ? fv1 : fv0;
  wire [1:0] fc_s = sel != 0 ? fc1 : fc0;
  wire busy_s = sel != 0 ? busy1 : busy0;
  wire done_s = sel != 0 ? done1 : done0;
  wire pass_s = sel != 0 ? pass1 : pass0;
  exhaustive_sweep_checker dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec(vec0), .dut_out(out0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .fail_code(fc0)
  );
  exhaustive_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec(vec1), .dut_out(out1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .fail_code(fc1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int s, input int mode, input int fv, input int poke);
    int ecode, evec, eedges, n;
    logic [2:0] o;
    bit poked, pulsing;
    ecode = 0;
    evec = 15;
    poked = 0;
    pulsing = 0;
    m_mode = mode;
    m_fv = fv;
    for (int v = 0; v < 16 && ecode == 0; v++) begin
      o = impl(4'(v), mode, fv, m_pat);
      if (o != 3'b000 && o != 3'b111) begin ecode = 1; evec = v; end
      else if (o[0] != GOLD[v]) begin ecode = 2; evec = v; end
    end
    eedges = (evec + 1) * (s + 1);
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    start1 = 1'b0;
    chk("start_busy", 32'(busy_s), 1);
    chk("start_done", 32'(done_s), 0);
    chk("start_pass", 32'(pass_s), 0);
    chk("start_vec", 32'(vec_s), 0);
    chk("start_fail_vec", 32'(fv_s), 0);
    chk("start_code", 32'(fc_s), 0);
    n = 0;
    while (n < 400 && !done_s) begin
      @(posedge clk);
      #1 n++;
      if (pulsing) begin start0 = 1'b0; start1 = 1'b0; pulsing = 0; end
      if (!done_s) begin
        chk("sweep_vec", 32'(vec_s), 32'(n / (s + 1)));
        chk("sweep_busy", 32'(busy_s), 1);
        if (!poked && int'(vec_s) == poke) begin
          poked = 1;
          pulsing = 1;
          if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        end
      end
    end
    chk("done_edges", 32'(n), 32'(eedges));
    chk("done_pass", 32'(pass_s), 32'(ecode == 0));
    chk("done_fail_vec", 32'(fv_s), ecode == 0 ? 0 : 32'(evec));
    chk("done_code", 32'(fc_s), 32'(ecode));
    chk("done_busy", 32'(busy_s), 0);
    chk("done_vec", 32'(vec_s), 32'(evec));
    repeat (3) @(posedge clk);
    #1 chk("hold_done", 32'(done_s), 1);
    chk("hold_vec", 32'(vec_s), 32'(evec));
    chk("hold_code", 32'(fc_s), 32'(ecode));
  endtask
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_vec", 32'(vec0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_fail_vec", 32'(fv0), 0);
    chk("rst_code", 32'(fc0), 0);
    rst = 1'b0;
    sel = 0;
    run(2, 0, 0, -1);
    run(2, 1, 7, -1);
    run(2, 2, 14, -1);
    run(2, 0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      m_pat = 3'($urandom_range(0, 7));
      run(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), -1);
    end
    m_mode = 0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int i = 0; i < 100 && vec0 != 4'd9; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_vec9", 32'(vec0), 9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_vec", 32'(vec0), 0);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_done", 32'(done0), 0);
    chk("midrst_pass", 32'(pass0), 0);
    repeat (2) @(posedge clk);
    #1 chk("midrst_idle_vec", 32'(vec0), 0);
    chk("midrst_idle_busy", 32'(busy0), 0);
    run(2, 0, 0, -1);
    sel = 1;
    run(1, 0, 0, -1);
    m_pat = 3'($urandom_range(1, 7));
    run(1, 3, int'($urandom_range(0, 15)), -1);
    run(1, 1, 5, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exhaustive_sweep_checker.md
Name: exhaustive_sweep_checker

Overview:
- Synthesizable stimulus-and-judge stage that sits around the parallel combinational implementations of a small truth-table function (gate-level, dataflow and behavioural).
- Upstream role: sweeps every input vector 0..2^IN_W-1 onto the shared input bus.
- Downstream role: samples the N_IMPL outputs and checks that they agree with each other and with a golden truth-table mask.
- Reports pass/fail with the first failing vector; used on-board and as a reusable bench core.

Parameters:
IN_W, 4, width of the swept input vector
N_IMPL, 3, number of parallel implementations compared
SETTLE, 2, wait cycles after driving a vector before sampling (legal range >= 1)
GOLDEN, 16'hC0A0, expected output per vector; bit k = expected out for vec==k (width 2^IN_W; default is true for 5, 7, 14, 15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
vec  output  IN_W  vector driven to all implementations
dut_out  input  N_IMPL  one output bit per implementation
busy  output  1  sweep in progress
done  output  1  sweep finished; holds until next start or reset
pass  output  1  valid when done=1; 1 = all vectors correct
fail_vec  output  IN_W  first failing vector; 0 when pass=1
fail_code  output  2  00 none, 01 implementations disagree, 10 all agree but differ from GOLDEN

Behaviour:
- Reset: one clock and synchronous active-high reset (clk, rst) as decided. rst=1 at a clock edge forces state IDLE and sets vec=0, busy=0, done=0, pass=0, fail_vec=0, fail_code=00, and settle count=0. Reset wins over any other event, including mid-sweep.
- State machine: IDLE, WAIT, CHECK, DONE.
- IDLE or DONE with start=1:
  - vec<=0, cnt<=0, busy<=1.
  - done, pass, fail_vec and fail_code are cleared.
  - Next state is WAIT.
- WAIT: cnt increments each cycle. When cnt==SETTLE-1, go to CHECK. vec is held stable.
- CHECK (single cycle, samples dut_out):
  - Disagreement is checked first. If dut_out is not all-0s or all-1s: fail_code<=01, fail_vec<=vec, pass<=0, go to DONE.
  - Otherwise, if dut_out[0]!=GOLDEN[vec]: fail_code<=10, fail_vec<=vec, pass<=0, go to DONE.
  - Otherwise, if vec==2^IN_W-1: pass<=1, fail_code<=00, go to DONE. No wrap to 0 occurs.
  - Otherwise: vec<=vec+1, cnt<=0, go to WAIT.
- DONE: busy=0, done=1. All result outputs and vec are held.
- start with busy=1 is ignored.
- Timing: each vector occupies SETTLE+1 cycles. For a passing sweep, done rises after exactly 2^IN_W*(SETTLE+1) edges following the edge that sampled start (48 for defaults). A failure terminates early at the failing vector's CHECK edge +0, i.e. done is visible the cycle after that CHECK.
- Width rules: vec is IN_W bits. The last-vector compare is done against an all-ones constant, so there is no overflow. cnt is sized as clog2(SETTLE)+1 bits.
- Outputs are registered. dut_out is treated as combinational from vec; no synchroniser is used.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT, CHECK, DONE)
  - fail-code constants FAIL_NONE=2'b00, FAIL_DISAGREE=2'b01, FAIL_GOLDEN=2'b10
  - default GOLDEN mask constant
- One sub-module, sweep_judge: purely combinational. Inputs are dut_out, vec and GOLDEN; outputs are agree, correct and code. The FSM and counters stay in the top.

Test Plan:
- Three correct models, defaults, start pulse at cycle 0 -> busy=1 for 48 cycles; done=1, pass=1, fail_code=00, fail_vec=0; vec held at 15.
- Implementation 1 inverted only at vec=7 -> done after the vec-7 CHECK (edge 24); pass=0, fail_code=01, fail_vec=7.
- All three models return 0 at vec=14 -> fail_code=10, fail_vec=14, done at edge 45.
- rst=1 for one cycle while vec=9 -> next cycle vec=0, busy=0, done=0, state IDLE; a new start then runs a full 48-cycle sweep.
- start pulsed at vec=3 mid-sweep -> no restart and vec continues. start in DONE -> flags clear and the sweep restarts at vec=0.
- SETTLE=1 override -> passing sweep completes in 32 cycles, and each vec is held exactly 2 cycles.
